// File: rtl/iserdes_align_pkg.sv
// Shared types and constants for the ISERDES2 frame-alignment sequencer.
//   align_state_e     : sequencer state encoding
//   SLIP_W            : width of the per-polarity bitslip counter
//   FRAME_PATTERN_DEF : default expected frame word (bits doubled by the 1:8 DDR PHY)
//   max3()            : helper used to size the shared wait timer
package iserdes_align_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CAL_WAIT_IDLE,
    ST_CAL_PULSE,
    ST_CAL_WAIT,
    ST_DLY_RST,
    ST_DLY_WAIT,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_SLIP_WAIT,
    ST_LOCKED,
    ST_FAIL
  } align_state_e;

  localparam int          SLIP_W            = 4;
  localparam logic [15:0] FRAME_PATTERN_DEF = 16'hFF00;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iserdes_frame_align_ctrl_if.sv
// Control/status bundle between the frame-alignment sequencer and the PHY.
//   start      : one-cycle (re)align request
//   busy       : slave IODELAY2 BUSY
//   frame_word : 16-bit PHY dout of the frame lane
//   cal_dly, rst_dly, bitslip, reva_flag : PHY control outputs
//   locked, fail, timeout, slip_cnt      : sequencer status
// master = sequencer side, slave = PHY/system side.
interface iserdes_frame_align_ctrl_if;
  import iserdes_align_pkg::*;

  logic              start;
  logic              busy;
  logic [15:0]       frame_word;
  logic              cal_dly;
  logic              rst_dly;
  logic              bitslip;
  logic              reva_flag;
  logic              locked;
  logic              fail;
  logic              timeout;
  logic [SLIP_W-1:0] slip_cnt;

  modport master (
    input  start, busy, frame_word,
    output cal_dly, rst_dly, bitslip, reva_flag, locked, fail, timeout, slip_cnt
  );

  modport slave (
    output start, busy, frame_word,
    input  cal_dly, rst_dly, bitslip, reva_flag, locked, fail, timeout, slip_cnt
  );

endinterface

// File: rtl/align_wait_timer.sv
// Loadable down-counter shared by the settle wait, the post-slip wait and the
// busy timeout.
//   clkdiv, reset_n : clock, async active-low reset
//   load, load_val  : (re)start the count; loading N gives done after N+1 cycles
//   done            : one-cycle pulse when the loaded count has run out
module align_wait_timer #(
  parameter int W = 10
) (
  input  logic         clkdiv,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - W'(1);
    end
  end

  // armed drops right after reaching zero, so done is a single-cycle pulse
  assign done = armed && (cnt == '0);

endmodule

// File: rtl/iserdes_frame_align_ctrl.sv
// Frame-alignment sequencer for the 1:8 DDR ISERDES2 frame-clock PHY.
// Calibrates and resets the IODELAY2 pair, then bitslips (and flips polarity
// once) until frame_word equals FRAME_PATTERN; monitors lock afterwards.
//   clkdiv  : PHY clkdiv domain clock
//   reset_n : async active-low reset; sequence auto-starts on release
//   bus     : control/status bundle (master side)
// All bus outputs come straight from flops.
module iserdes_frame_align_ctrl
  import iserdes_align_pkg::*;
#(
  parameter int          DATA_WIDTH    = 8,
  parameter logic [15:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
  parameter int          MATCH_COUNT   = 4,
  parameter int          MISS_LIMIT    = 4,
  parameter int          SLIP_WAIT     = 4,
  parameter int          SETTLE_CYCLES = 16,
  parameter int          BUSY_TIMEOUT  = 1023
) (
  input  logic clkdiv,
  input  logic reset_n,
  iserdes_frame_align_ctrl_if.master bus
);

  localparam int TMR_W = $clog2(max3(BUSY_TIMEOUT, SETTLE_CYCLES, SLIP_WAIT) + 1);
  // timer fires load_val+1 cycles after loading, so load N-1 for an N-cycle wait
  localparam logic [TMR_W-1:0] BUSY_LD   = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SLIP_LD   = TMR_W'(SLIP_WAIT - 1);

  align_state_e      state, state_n;
  logic [SLIP_W-1:0] slip_q, slip_n;
  logic              reva_q, reva_n;
  logic [3:0]        match_q, match_n, miss_q, miss_n;
  logic              rise_q, rise_n;      // busy seen high during CAL_WAIT
  logic              to_q, to_n;
  logic              req_q, req_n;        // pending start (also the boot request)
  logic              cal_q, rst_q, slip_pulse_q, locked_q, fail_q;
  logic              tmr_load, tmr_done;
  logic [TMR_W-1:0]  tmr_val;
  logic              go_cal, to_fail, hit;

  assign hit = (bus.frame_word == FRAME_PATTERN);

  align_wait_timer #(.W(TMR_W)) u_tmr (
    .clkdiv   (clkdiv),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n  = state;
    slip_n   = slip_q;
    reva_n   = reva_q;
    match_n  = match_q;
    miss_n   = miss_q;
    rise_n   = rise_q;
    to_n     = to_q;
    req_n    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    go_cal   = 1'b0;
    to_fail  = 1'b0;

    case (state)
      ST_IDLE: go_cal = bus.start || req_q;

      ST_CAL_WAIT_IDLE: begin
        if (!bus.busy)    state_n = ST_CAL_PULSE;
        else if (tmr_done) to_fail = 1'b1;
      end

      ST_CAL_PULSE: begin
        state_n  = ST_CAL_WAIT;
        rise_n   = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = BUSY_LD;
      end

      // rising busy counts as progress and restarts the timeout
      ST_CAL_WAIT: begin
        if (!rise_q) begin
          if (bus.busy) begin
            rise_n   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = BUSY_LD;
          end else if (tmr_done) to_fail = 1'b1;
        end else begin
          if (!bus.busy)     state_n = ST_DLY_RST;
          else if (tmr_done) to_fail = 1'b1;
        end
      end

      ST_DLY_RST: begin
        state_n  = ST_DLY_WAIT;
        tmr_load = 1'b1;
        tmr_val  = BUSY_LD;
      end

      ST_DLY_WAIT: begin
        if (!bus.busy) begin
          state_n  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end else if (tmr_done) to_fail = 1'b1;
      end

      ST_SETTLE: begin
        if (tmr_done) begin
          state_n = ST_CHECK;
          slip_n  = '0;
          reva_n  = 1'b0;
          match_n = '0;
        end
      end

      ST_CHECK: begin
        if (req_q) go_cal = 1'b1;
        else if (hit) begin
          if (int'(match_q) + 1 >= MATCH_COUNT) begin
            state_n = ST_LOCKED;
            match_n = '0;
            miss_n  = '0;
          end else match_n = match_q + 4'd1;
        end else begin
          match_n = '0;
          state_n = ST_SLIP;
        end
      end

      // the DATA_WIDTH-th slip brings the lane back to its starting phase,
      // so that is where polarity is flipped (or alignment abandoned)
      ST_SLIP: begin
        tmr_load = 1'b1;
        tmr_val  = SLIP_LD;
        if (slip_q == SLIP_W'(DATA_WIDTH - 1)) begin
          if (!reva_q) begin
            reva_n  = 1'b1;
            slip_n  = '0;
            state_n = ST_SLIP_WAIT;
          end else begin
            state_n = ST_FAIL;
            req_n   = bus.start;
          end
        end else begin
          slip_n  = slip_q + SLIP_W'(1);
          state_n = ST_SLIP_WAIT;
        end
      end

      ST_SLIP_WAIT: if (tmr_done) state_n = ST_CHECK;

      // loss of lock wins over start; a coincident start is replayed from CHECK
      ST_LOCKED: begin
        if (!hit && (int'(miss_q) + 1 >= MISS_LIMIT)) begin
          state_n = ST_CHECK;
          miss_n  = '0;
          match_n = '0;
          req_n   = bus.start;
        end else if (bus.start) go_cal = 1'b1;
        else if (hit)           miss_n = '0;
        else                    miss_n = miss_q + 4'd1;
      end

      ST_FAIL: go_cal = bus.start || req_q;

      default: state_n = ST_IDLE;
    endcase

    if (to_fail) begin
      state_n = ST_FAIL;
      to_n    = 1'b1;
      req_n   = bus.start;
    end
    if (go_cal) begin
      state_n  = ST_CAL_WAIT_IDLE;
      tmr_load = 1'b1;
      tmr_val  = BUSY_LD;
      rise_n   = 1'b0;
      to_n     = 1'b0;
    end
  end

  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      slip_q       <= '0;
      reva_q       <= 1'b0;
      match_q      <= '0;
      miss_q       <= '0;
      rise_q       <= 1'b0;
      to_q         <= 1'b0;
      req_q        <= 1'b1;   // auto-start after reset
      cal_q        <= 1'b0;
      rst_q        <= 1'b0;
      slip_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state        <= state_n;
      slip_q       <= slip_n;
      reva_q       <= reva_n;
      match_q      <= match_n;
      miss_q       <= miss_n;
      rise_q       <= rise_n;
      to_q         <= to_n;
      req_q        <= req_n;
      cal_q        <= (state_n == ST_CAL_PULSE);
      rst_q        <= (state_n == ST_DLY_RST);
      slip_pulse_q <= (state_n == ST_SLIP);
      locked_q     <= (state_n == ST_LOCKED);
      fail_q       <= (state_n == ST_FAIL);
    end
  end

  assign bus.cal_dly   = cal_q;
  assign bus.rst_dly   = rst_q;
  assign bus.bitslip   = slip_pulse_q;
  assign bus.reva_flag = reva_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.timeout   = to_q;
  assign bus.slip_cnt  = slip_q;

endmodule

// File: tb/tb_iserdes_frame_align_ctrl.sv
// Directed bench for iserdes_frame_align_ctrl with a small PHY model:
// busy pulses 10 cycles after each cal_dly; the frame lane phase advances on
// every bitslip and matches FRAME_PATTERN only at the target phase.
module tb_iserdes_frame_align_ctrl;
  import iserdes_align_pkg::*;

  localparam logic [15:0] PAT = 16'hFF00;

  logic clkdiv = 1'b0;
  logic reset_n;
  always #5 clkdiv = ~clkdiv;

  iserdes_frame_align_ctrl_if bus();

  iserdes_frame_align_ctrl dut (
    .clkdiv  (clkdiv),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clkdiv) cyc <= cyc + 1;

  // model state written by the PHY model process
  int cal_tot = 0, rst_tot = 0, slip_tot = 0, rst_cyc = 0;
  int slip_q[$];
  // model controls written by the main sequence
  int phase_base = 0, target = 0;
  bit busy_stuck = 0, ovr = 0, nomatch = 0, inv_mode = 0;

  // PHY model, evaluated 1 time unit after each falling edge
  initial begin
    int bcnt, phase;
    logic [15:0] w;
    bcnt = 0;
    bus.busy = 1'b0;
    bus.frame_word = PAT;
    forever begin
      @(negedge clkdiv);
      #1;
      if (bus.cal_dly) cal_tot++;
      if (bus.rst_dly) begin rst_tot++; rst_cyc = cyc; end
      if (bus.bitslip) begin slip_tot++; slip_q.push_back(cyc); end
      if (busy_stuck) bus.busy = 1'b1;
      else begin
        if (bus.cal_dly)   bcnt = 10;
        else if (bcnt > 0) bcnt--;
        bus.busy = (bcnt > 0);
      end
      phase = (slip_tot - phase_base) % 8;
      if (ovr)                          w = ~PAT;
      else if (nomatch)                 w = 16'h1234;
      else if (inv_mode && !bus.reva_flag) w = ~PAT;
      else if (phase == target)         w = PAT;
      else                              w = 16'h0FF0;
      bus.frame_word = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clkdiv);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clkdiv);
    bus.start = 1'b0;
  endtask

  task automatic wait_lock(input string tag, output int lc);
    lc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clkdiv);
      if (bus.locked) begin lc = cyc; break; end
    end
    chk(tag, bus.locked, 1);
  endtask

  task automatic wait_fail(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clkdiv);
      if (bus.fail) break;
    end
    chk(tag, bus.fail, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cal"},     bus.cal_dly, 0);
    chk({tag, "_rst"},     bus.rst_dly, 0);
    chk({tag, "_bitslip"}, bus.bitslip, 0);
    chk({tag, "_reva"},    bus.reva_flag, 0);
    chk({tag, "_locked"},  bus.locked, 0);
    chk({tag, "_fail"},    bus.fail, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
    chk({tag, "_slipcnt"}, bus.slip_cnt, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lc, base, cb, n, sp1, sp2;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // pre-aligned: lock 1 (DLY_RST) + 1 (DLY_WAIT) + 16 settle + 4 matches after rst_dly
    wait_lock("t1_lock", lc);
    chk("t1_lock_latency", lc - rst_cyc, 22);
    chk("t1_cal_pulses", cal_tot, 1);
    chk("t1_rst_pulses", rst_tot, 1);
    chk("t1_slips", slip_tot, 0);
    chk("t1_slip_cnt", bus.slip_cnt, 0);
    chk("t1_fail", bus.fail, 0);

    // 3-bit offset: 3 slips, 6 cycles apart
    target = 3; phase_base = slip_tot; base = slip_q.size(); cb = cal_tot;
    pulse_start();
    wait_lock("t2_lock", lc);
    sp1 = (slip_q.size() >= base + 3) ? slip_q[base+1] - slip_q[base]   : -1;
    sp2 = (slip_q.size() >= base + 3) ? slip_q[base+2] - slip_q[base+1] : -1;
    chk("t2_slips", slip_tot - phase_base, 3);
    chk("t2_spacing1", sp1, 6);
    chk("t2_spacing2", sp2, 6);
    chk("t2_slip_cnt", bus.slip_cnt, 3);
    chk("t2_reva", bus.reva_flag, 0);
    chk("t2_cal_pulses", cal_tot - cb, 1);

    // 3 misses hold lock, 4 misses drop it; relock keeps slip_cnt
    ovr = 1; tick(3); ovr = 0;
    chk("t6_3miss_locked", bus.locked, 1);
    tick(6);
    chk("t6_3miss_locked_later", bus.locked, 1);
    ovr = 1; tick(4); ovr = 0;
    chk("t6_4miss_unlocked", bus.locked, 0);
    wait_lock("t6_relock", lc);
    chk("t6_slip_cnt_kept", bus.slip_cnt, 3);
    chk("t6_no_new_slips", slip_tot - phase_base, 3);

    // inverted frame: 8 slips then polarity flip
    inv_mode = 1; target = 0; phase_base = slip_tot;
    pulse_start();
    wait_lock("t3_lock", lc);
    chk("t3_slips", slip_tot - phase_base, 8);
    chk("t3_reva", bus.reva_flag, 1);
    chk("t3_slip_cnt", bus.slip_cnt, 0);

    // never matches: 16 slips then fail without timeout
    inv_mode = 0; nomatch = 1; phase_base = slip_tot;
    pulse_start();
    wait_fail("t4_fail");
    chk("t4_slips", slip_tot - phase_base, 16);
    chk("t4_timeout", bus.timeout, 0);
    chk("t4_locked", bus.locked, 0);
    nomatch = 0; phase_base = slip_tot;
    pulse_start();
    chk("t4_fail_cleared", bus.fail, 0);
    @(negedge clkdiv);
    chk("t4_restart_cal", bus.cal_dly, 1);
    wait_lock("t4_relock", lc);

    // busy stuck high: timeout after 1023 cycles in CAL_WAIT_IDLE
    busy_stuck = 1;
    pulse_start();
    tick(1022);
    chk("t5_fail_early", bus.fail, 0);
    tick(1);
    chk("t5_fail", bus.fail, 1);
    chk("t5_timeout", bus.timeout, 1);
    busy_stuck = 0;
    pulse_start();
    chk("t5_timeout_cleared", bus.timeout, 0);
    chk("t5_fail_cleared", bus.fail, 0);
    wait_lock("t5_relock", lc);

    // async reset during the slip sequence
    target = 3; phase_base = slip_tot;
    pulse_start();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clkdiv);
      if (bus.bitslip) n++;
      if (n == 2) break;
    end
    chk("t7_second_slip", n, 2);
    chk("t7_slip_cnt_before", bus.slip_cnt, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t7_async");
    tick(2);
    target = 0; phase_base = slip_tot;
    reset_n = 1'b1;
    wait_lock("t7_relock", lc);
    chk("t7_relock_slip_cnt", bus.slip_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
